// File: rtl/xalu_md_sched.sv
// xalu_md_sched - E-stage multiply/divide unit with HI/LO registers.
//
// Executes mult, multu, div, divu and madd over a fixed number of busy
// cycles. It also handles mthi/mtlo writes and supplies HI/LO read data for
// mfhi/mflo. It requests a D-stage stall whenever a following md instruction
// would reach the unit while it is busy.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous active-high reset, clears all state
//   op_valid   in   1   E-stage instruction is an md op this cycle
//   op         in   4   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MADD,
//                       6 MTHI,7 MTLO,8 MFHI,9 MFLO
//   rs_val     in   32  forwarded rs operand
//   rt_val     in   32  forwarded rt operand
//   d_uses_md  in   1   D-stage instruction is an md op
//   busy       out  1   sequencer is in BUSY; this is the FSM state observable
//   stall_req  out  1   stall the D stage
//   hi, lo     out  32  HI / LO registers
//   rd_data    out  32  mfhi/mflo read data, 0 for every other op
//
// Handshake: an op is taken only when op_valid is high and the unit is IDLE.
// While busy, stall_req keeps new md ops out of E. Any op that still arrives
// during BUSY is ignored.
module xalu_md_sched #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [3:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        d_uses_md,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rd_data
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MADD  = 4'd5;
   localparam logic [3:0] OP_MTHI  = 4'd6;
   localparam logic [3:0] OP_MTLO  = 4'd7;
   localparam logic [3:0] OP_MFHI  = 4'd8;
   localparam logic [3:0] OP_MFLO  = 4'd9;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] rs_q, rs_d;
   logic [31:0] rt_q, rt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        start;
   logic        start_is_div;

   // Arithmetic is computed from the latched operands. MADD adds to the
   // HI/LO value present on the commit edge.
   logic [63:0] prod_s, prod_u, madd_sum;
   logic [31:0] rs_mag, rt_mag, sdiv_den, udiv_den;
   logic [31:0] q_mag, r_mag, sdiv_q, sdiv_r;

   assign start        = op_valid && (state_q == S_IDLE) && (op >= OP_MULT) && (op <= OP_MADD);
   assign start_is_div = (op == OP_DIV) || (op == OP_DIVU);

   assign prod_s   = 64'($signed({{32{rs_q[31]}}, rs_q}) * $signed({{32{rt_q[31]}}, rt_q}));
   assign prod_u   = {32'd0, rs_q} * {32'd0, rt_q};
   assign madd_sum = {hi_q, lo_q} + prod_s;

   // Signed divide is done on magnitudes. This gives truncation toward zero
   // and a remainder that takes the sign of the dividend. It also makes
   // 0x80000000 / -1 wrap to 0x80000000 without special casing.
   // A zero divisor is replaced by 1 so the dividers never see 0. That
   // result is discarded at commit.
   assign rs_mag   = rs_q[31] ? (32'd0 - rs_q) : rs_q;
   assign rt_mag   = rt_q[31] ? (32'd0 - rt_q) : rt_q;
   assign sdiv_den = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
   assign udiv_den = (rt_q == 32'd0) ? 32'd1 : rt_q;
   assign q_mag    = rs_mag / sdiv_den;
   assign r_mag    = rs_mag % sdiv_den;
   assign sdiv_q   = (rs_q[31] ^ rt_q[31]) ? (32'd0 - q_mag) : q_mag;
   assign sdiv_r   = rs_q[31] ? (32'd0 - r_mag) : r_mag;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         op_q    <= 4'd0;
         rs_q    <= 32'd0;
         rt_q    <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_BUSY;
               cnt_d   = start_is_div ? 4'(DIV_LAT) : 4'(MULT_LAT);
               op_d    = op;
               rs_d    = rs_val;
               rt_d    = rt_val;
            end else if (op_valid && (op == OP_MTHI)) begin
               hi_d = rs_val;
            end else if (op_valid && (op == OP_MTLO)) begin
               lo_d = rs_val;
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_IDLE;
               case (op_q)
                  OP_MULT:  {hi_d, lo_d} = prod_s;
                  OP_MULTU: {hi_d, lo_d} = prod_u;
                  OP_MADD:  {hi_d, lo_d} = madd_sum;
                  OP_DIV: begin
                     if (rt_q != 32'd0) begin
                        lo_d = sdiv_q;
                        hi_d = sdiv_r;
                     end
                  end
                  OP_DIVU: begin
                     if (rt_q != 32'd0) begin
                        lo_d = rs_q / udiv_den;
                        hi_d = rs_q % udiv_den;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q == S_BUSY);
   assign stall_req = d_uses_md && (busy || start);
   assign hi        = hi_q;
   assign lo        = lo_q;

   always_comb begin
      rd_data = 32'd0;
      if (op_valid && (op == OP_MFHI)) rd_data = hi_q;
      else if (op_valid && (op == OP_MFLO)) rd_data = lo_q;
   end

endmodule

// File: tb/tb_xalu_md_sched.sv
module tb_xalu_md_sched;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [3:0]  op;
   logic [31:0] rs_val, rt_val;
   logic        d_uses_md;
   logic        busy, stall_req;
   logic [31:0] hi, lo, rd_data;

   int errors = 0;
   int checks = 0;

   xalu_md_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .d_uses_md(d_uses_md),
      .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .rd_data(rd_data)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Presents one op for a single cycle. Returns at the negedge after the
   // accepting edge.
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
      @(negedge clk);
      op_valid = 1'b0; op = 4'd0;
   endtask

   // Counts cycles with busy high, bounded. The caller compares the count.
   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   logic [31:0] m_hi, m_lo, m_rs, m_rt;
   logic [3:0]  m_op;
   int          m_left;

   function automatic void model_commit();
      longint          a, b, q, r, p;
      longint unsigned pu;
      logic [63:0]     acc;
      a = longint'($signed(m_rs));
      b = longint'($signed(m_rt));
      case (m_op)
         4'd1: begin p = a * b; {m_hi, m_lo} = p; end
         4'd2: begin pu = longint'(m_rs) * longint'(m_rt); {m_hi, m_lo} = pu; end
         4'd5: begin p = a * b; acc = {m_hi, m_lo}; acc = acc + p; {m_hi, m_lo} = acc; end
         4'd3: if (m_rt != 0) begin
            q = a / b; r = a % b;
            m_lo = q[31:0]; m_hi = r[31:0];
         end
         4'd4: if (m_rt != 0) begin
            m_lo = m_rs / m_rt; m_hi = m_rs % m_rt;
         end
         default: ;
      endcase
   endfunction

   // Advances the model across one clock edge using the inputs now applied.
   function automatic void model_edge();
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0) model_commit();
      end else if (op_valid && op >= 4'd1 && op <= 4'd5) begin
         m_left = (op == 4'd3 || op == 4'd4) ? DIV_LAT : MULT_LAT;
         m_op = op; m_rs = rs_val; m_rt = rt_val;
      end else if (op_valid && op == 4'd6) begin
         m_hi = rs_val;
      end else if (op_valid && op == 4'd7) begin
         m_lo = rs_val;
      end
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      int          lat;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[12];

   task automatic set_vec(input int i, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int l, input logic [31:0] eh, input logic [31:0] el);
      vecs[i].op = o; vecs[i].rs = a; vecs[i].rt = b;
      vecs[i].lat = l; vecs[i].exp_hi = eh; vecs[i].exp_lo = el;
   endtask

   // ---------------- main test ----------------
   initial begin
      int n;
      logic exp_busy, exp_start, exp_stall;
      logic [31:0] exp_rd;

      // Entries run in order; each expectation includes the HI/LO left by earlier ones.
      set_vec(0,  4'd6, 32'h0000_0001, 32'd0,          0,        32'h0000_0001, 32'h0000_0000);
      set_vec(1,  4'd7, 32'hFFFF_FFFF, 32'd0,          0,        32'h0000_0001, 32'hFFFF_FFFF);
      set_vec(2,  4'd5, 32'd1,         32'd1,          MULT_LAT, 32'h0000_0002, 32'h0000_0000);
      set_vec(3,  4'd1, 32'hFFFF_FFFE, 32'd3,          MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      set_vec(4,  4'd2, 32'hFFFF_FFFE, 32'd3,          MULT_LAT, 32'h0000_0002, 32'hFFFF_FFFA);
      set_vec(5,  4'd3, 32'hFFFF_FFF9, 32'd2,          DIV_LAT,  32'hFFFF_FFFF, 32'hFFFF_FFFD);
      set_vec(6,  4'd3, 32'd5,         32'd0,          DIV_LAT,  32'hFFFF_FFFF, 32'hFFFF_FFFD);
      set_vec(7,  4'd3, 32'h8000_0000, 32'hFFFF_FFFF,  DIV_LAT,  32'h0000_0000, 32'h8000_0000);
      set_vec(8,  4'd4, 32'd7,         32'd2,          DIV_LAT,  32'h0000_0001, 32'h0000_0003);
      set_vec(9,  4'd4, 32'hFFFF_FFFF, 32'd16,         DIV_LAT,  32'h0000_000F, 32'h0FFF_FFFF);
      set_vec(10, 4'd5, 32'hFFFF_FFFF, 32'd1,          MULT_LAT, 32'h0000_000F, 32'h0FFF_FFFE);
      set_vec(11, 4'd1, 32'h8000_0000, 32'h8000_0000,  MULT_LAT, 32'h4000_0000, 32'h0000_0000);

      reset = 1'b1; op_valid = 1'b0; op = 4'd0; rs_val = 32'd0; rt_val = 32'd0; d_uses_md = 1'b0;
      repeat (2) @(negedge clk);
      check32("reset_busy", {31'd0, busy}, 32'd0);
      check32("reset_stall", {31'd0, stall_req}, 32'd0);
      check32("reset_hi", hi, 32'd0);
      check32("reset_lo", lo, 32'd0);
      reset = 1'b0;

      // Table: latency and HI/LO result of each op.
      for (int i = 0; i < 12; i++) begin
         issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
         count_busy(n);
         check_int($sformatf("vec%0d_latency", i), n, vecs[i].lat);
         check32($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
         check32($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      end

      // Asynchronous reset in the middle of a DIV, when cnt has counted down to 4.
      @(negedge clk);
      op_valid = 1'b1; op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
      @(negedge clk);
      op_valid = 1'b0; op = 4'd0;
      repeat (6) @(negedge clk);
      check32("middiv_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check32("async_reset_busy", {31'd0, busy}, 32'd0);
      check32("async_reset_hi", hi, 32'd0);
      check32("async_reset_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      issue(4'd1, 32'd6, 32'd7);
      count_busy(n);
      check_int("post_reset_mult_latency", n, MULT_LAT);
      check32("post_reset_mult_lo", lo, 32'd42);
      check32("post_reset_mult_hi", hi, 32'd0);

      // Stall window: start cycle plus MULT_LAT busy cycles, with d_uses_md held.
      @(negedge clk);
      d_uses_md = 1'b1;
      op_valid = 1'b1; op = 4'd1; rs_val = 32'h0001_2345; rt_val = 32'h0000_0010;
      #1;
      check32("stall_on_start", {31'd0, stall_req}, 32'd1);
      @(negedge clk);
      op_valid = 1'b0; op = 4'd0;
      n = 0;
      while (stall_req === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      check_int("stall_busy_cycles", n, MULT_LAT);
      check32("stall_after_commit", {31'd0, stall_req}, 32'd0);
      op_valid = 1'b1; op = 4'd9;
      #1;
      check32("mflo_after_mult", rd_data, 32'h0012_3450);
      check32("mflo_no_stall_idle", {31'd0, stall_req}, 32'd0);
      @(negedge clk);
      op_valid = 1'b0; d_uses_md = 1'b0;

      // mfhi / NONE read mux.
      issue(4'd6, 32'hCAFE_F00D, 32'd0);
      op_valid = 1'b1; op = 4'd8;
      #1;
      check32("mfhi_rd", rd_data, 32'hCAFE_F00D);
      op = 4'd0;
      #1;
      check32("none_rd", rd_data, 32'd0);
      op = 4'd9;
      #1;
      check32("mflo_rd", rd_data, 32'h0012_3450);
      @(negedge clk);
      op_valid = 1'b0; op = 4'd0;

      // Randomized traffic against the reference model.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_op = 4'd0; m_rs = 32'd0; m_rt = 32'd0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         // Md ops are only driven while the model is idle, as the stall guarantees in the pipeline.
         op_valid  = (m_left == 0) && ($urandom_range(0, 3) != 0);
         op        = 4'($urandom_range(0, 9));
         rs_val    = pick_operand();
         rt_val    = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_operand();
         d_uses_md = 1'($urandom_range(0, 1));
         #1;
         exp_busy  = (m_left > 0);
         exp_start = op_valid && (m_left == 0) && (op >= 4'd1) && (op <= 4'd5);
         exp_stall = d_uses_md && (exp_busy || exp_start);
         exp_rd    = !op_valid ? 32'd0 : (op == 4'd8) ? m_hi : (op == 4'd9) ? m_lo : 32'd0;
         check32("rand_busy", {31'd0, busy}, {31'd0, exp_busy});
         check32("rand_stall", {31'd0, stall_req}, {31'd0, exp_stall});
         check32("rand_hi", hi, m_hi);
         check32("rand_lo", lo, m_lo);
         if (op_valid) check32("rand_rd", rd_data, exp_rd);
         model_edge();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
